// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: turns a command/write-data stream into SINGLE/INCR/WRAP bursts.
// Define AHB_BURST_WRAP_EN to build wrapping bursts; otherwise WRAP codes run as INCR.
module ahb_burst_master (
    input  logic        clk,
    input  logic        hreset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_burst,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    input  logic [31:0] wdata,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  htrans,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hburst,
    output logic [2:0]  hsize,
    output logic [6:0]  hprot,
    output logic        hmastlock,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic [31:0] hrdata,
    input  logic        hresp
);
    localparam logic [1:0] HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NSEQ = 2'b10, HT_SEQ = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;

    state_t      r_state;
    logic        r_live;
    logic [1:0]  r_htrans;
    logic [31:0] r_haddr, r_addr, r_hwdata, r_wbuf, r_rdata;
    logic        r_hwrite, r_dwrite, r_dphase, r_first, r_rdata_valid, r_err;
    logic [2:0]  r_hburst;
    logic [3:0]  r_left;

    logic [31:0] w_a0, w_a0_next, w_addr_next;
    logic [2:0]  w_cmd_hburst;
    logic [3:0]  w_cmd_beats;
    logic        w_incr, w_accept, w_slot, w_issue_cmd, w_issue_seq, w_err1;

`ifdef AHB_BURST_WRAP_EN
    typedef enum logic [1:0] {M_INCR, M_WRAP4, M_WRAP8} mode_t;
    mode_t w_cmd_mode, r_mode;

    // Wrapping only touches the beat-index bits; upper address bits are held.
    function automatic logic [31:0] f_next(input logic [31:0] a, input mode_t m);
        case (m)
            M_WRAP4: return {a[31:4], a[3:2] + 2'd1, 2'b00};
            M_WRAP8: return {a[31:5], a[4:2] + 3'd1, 2'b00};
            default: return a + 32'd4;
        endcase
    endfunction

    assign w_a0_next   = f_next(w_a0, w_cmd_mode);
    assign w_addr_next = f_next(r_addr, r_mode);
    assign w_incr      = (r_mode == M_INCR);

    always_ff @(posedge clk or negedge hreset_n) begin
        if (!hreset_n)     r_mode <= M_INCR;
        else if (w_accept) r_mode <= w_cmd_mode;
    end
`else
    assign w_a0_next   = w_a0 + 32'd4;
    assign w_addr_next = r_addr + 32'd4;
    assign w_incr      = 1'b1;
`endif

    always_comb begin
        w_cmd_hburst = 3'b000;
        w_cmd_beats  = 4'd1;
`ifdef AHB_BURST_WRAP_EN
        w_cmd_mode   = M_INCR;
`endif
        case (cmd_burst)
`ifdef AHB_BURST_WRAP_EN
            3'b010: begin w_cmd_hburst = 3'b010; w_cmd_beats = 4'd4; w_cmd_mode = M_WRAP4; end
            3'b100: begin w_cmd_hburst = 3'b100; w_cmd_beats = 4'd8; w_cmd_mode = M_WRAP8; end
`else
            3'b010: begin w_cmd_hburst = 3'b011; w_cmd_beats = 4'd4; end
            3'b100: begin w_cmd_hburst = 3'b101; w_cmd_beats = 4'd8; end
`endif
            3'b011: begin w_cmd_hburst = 3'b011; w_cmd_beats = 4'd4; end
            3'b101: begin w_cmd_hburst = 3'b101; w_cmd_beats = 4'd8; end
            default: ;
        endcase
    end

    assign w_a0        = cmd_addr & 32'hFFFF_FFFC;
    // A new command may only start once no data phase (or error response) is outstanding.
    assign cmd_ready   = r_live && (r_state == S_IDLE || (r_state == S_DRAIN && hready && !hresp));
    assign w_accept    = cmd_ready && cmd_valid;
    assign w_slot      = (r_state == S_BURST) && hready && (r_left != 4'd0);
    assign w_issue_cmd = w_accept && (!cmd_write || wdata_valid);
    assign w_issue_seq = w_slot && (!r_hwrite || wdata_valid);
    assign wdata_ready = (w_accept && cmd_write && wdata_valid) || (w_slot && r_hwrite && wdata_valid);
    assign w_err1      = r_dphase && hresp && !hready;

    always_ff @(posedge clk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_state       <= S_IDLE;
            r_live        <= 1'b0;
            r_htrans      <= HT_IDLE;
            r_haddr       <= '0;
            r_addr        <= '0;
            r_hwrite      <= 1'b0;
            r_hburst      <= '0;
            r_hwdata      <= '0;
            r_wbuf        <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_dwrite      <= 1'b0;
            r_dphase      <= 1'b0;
            r_first       <= 1'b0;
            r_left        <= '0;
            r_err         <= 1'b0;
        end else begin
            r_live        <= 1'b1;
            r_rdata_valid <= 1'b0;
            if (hready) r_dphase <= r_htrans[1];
            if (r_htrans[1] && hready) begin
                r_dwrite <= r_hwrite;
                if (r_hwrite) r_hwdata <= r_wbuf;
            end
            if (wdata_ready) r_wbuf <= wdata;
            if (r_dphase && hready && !hresp && !r_dwrite) begin
                r_rdata_valid <= 1'b1;
                r_rdata       <= hrdata;
            end

            if (w_err1) begin
                // First error cycle: drop the rest of the burst, wait out the second cycle.
                r_htrans <= HT_IDLE;
                r_left   <= '0;
                r_err    <= 1'b1;
                r_state  <= S_DRAIN;
            end else if (w_accept) begin
                r_err    <= 1'b0;
                r_hwrite <= cmd_write;
                r_hburst <= w_cmd_hburst;
                r_haddr  <= w_a0;
                r_htrans <= w_issue_cmd ? HT_NSEQ : HT_IDLE;
                r_addr   <= w_issue_cmd ? w_a0_next : w_a0;
                r_left   <= w_issue_cmd ? w_cmd_beats - 4'd1 : w_cmd_beats;
                r_first  <= !w_issue_cmd;
                r_state  <= S_BURST;
            end else begin
                case (r_state)
                    S_BURST: if (hready) begin
                        if (r_left == 4'd0) begin
                            r_htrans <= HT_IDLE;
                            r_state  <= S_DRAIN;
                        end else begin
                            r_haddr <= r_addr;
                            if (w_issue_seq) begin
                                r_htrans <= (r_first || (w_incr && r_addr[9:0] == 10'd0)) ? HT_NSEQ : HT_SEQ;
                                r_addr   <= w_addr_next;
                                r_left   <= r_left - 4'd1;
                                r_first  <= 1'b0;
                            end else begin
                                r_htrans <= r_first ? HT_IDLE : HT_BUSY;
                            end
                        end
                    end
                    S_DRAIN: if (hready) r_state <= S_IDLE;
                    default: ;
                endcase
            end
        end
    end

    assign htrans      = r_htrans;
    assign haddr       = r_haddr;
    assign hwrite      = r_hwrite;
    assign hburst      = r_hburst;
    assign hwdata      = r_hwdata;
    assign hsize       = 3'b010;
    assign hprot       = 7'b0000001;
    assign hmastlock   = 1'b0;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign err         = r_err;
endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: zero-wait burst table plus BUSY, stall, error and reset sequences.
module tb_ahb_burst_master;
    logic        clk = 1'b0, hreset_n = 1'b0;
    logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
    logic [31:0] cmd_addr = 0;
    logic [2:0]  cmd_burst = 0;
    logic        wdata_valid = 0, wdata_ready;
    logic [31:0] wdata = 0;
    logic        rdata_valid, err;
    logic [31:0] rdata;
    logic [1:0]  htrans;
    logic [31:0] haddr, hwdata;
    logic        hwrite, hmastlock;
    logic [2:0]  hburst, hsize;
    logic [6:0]  hprot;
    logic        hready = 1, hresp = 0;
    logic [31:0] hrdata = 0;

    int tot = 0, bad = 0;

    ahb_burst_master dut (
        .clk(clk), .hreset_n(hreset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_burst(cmd_burst),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .err(err),
        .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hburst(hburst),
        .hsize(hsize), .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
        .hready(hready), .hrdata(hrdata), .hresp(hresp)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_htrans"}, htrans, 0);
        chk({tag, "_haddr"}, haddr, 0);
        chk({tag, "_hwrite"}, hwrite, 0);
        chk({tag, "_hburst"}, hburst, 0);
        chk({tag, "_hwdata"}, hwdata, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_wdata_ready"}, wdata_ready, 0);
        chk({tag, "_rdata_valid"}, rdata_valid, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic step(input logic wv, input logic [31:0] wd);
        @(negedge clk);
        cmd_valid = 0; wdata_valid = wv; wdata = wd;
        #1;
    endtask

    task automatic bus(input string nm, input logic [1:0] tr, input logic [31:0] ad);
        chk({nm, "_htrans"}, htrans, tr);
        chk({nm, "_haddr"}, ad === 32'hx ? haddr : ad, ad);
    endtask

    task automatic send(input logic wr, input logic [31:0] ad, input logic [2:0] bu, input logic wv, input logic [31:0] wd);
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = ad; cmd_burst = bu;
        wdata_valid = wv; wdata = wd;
        #1;
        chk("send_cmd_ready", cmd_ready, 1);
    endtask

    function automatic logic [31:0] wdv(input int i, input int b);
        return 32'hA0 + 32'(i) * 32'h100 + 32'(b);
    endfunction
    function automatic logic [31:0] rdv(input int i, input int b);
        return 32'hD000_0000 + 32'(i) * 32'h100 + 32'(b);
    endfunction

    typedef struct {
        logic             wr;
        logic [31:0]      addr;
        logic [2:0]       burst;
        int               n;
        logic [2:0]       hb;
        logic [7:0]       ns;
        logic [7:0][31:0] ea;
    } vec_t;
    vec_t vt[8];

    task automatic setv(input int i, input logic wr, input logic [31:0] ad, input logic [2:0] bu,
                        input int n, input logic [2:0] hb, input logic [7:0] ns,
                        input logic [31:0] e0, e1, e2, e3, e4, e5, e6, e7);
        vt[i].wr = wr; vt[i].addr = ad; vt[i].burst = bu; vt[i].n = n; vt[i].hb = hb; vt[i].ns = ns;
        vt[i].ea[0] = e0; vt[i].ea[1] = e1; vt[i].ea[2] = e2; vt[i].ea[3] = e3;
        vt[i].ea[4] = e4; vt[i].ea[5] = e5; vt[i].ea[6] = e6; vt[i].ea[7] = e7;
    endtask

    logic [31:0] stall_exp[8];
    logic [31:0] q_addr[$], q_rd[$];

    initial begin
        setv(0, 1, 32'h10,  3'b011, 4, 3'b011, 8'h01, 32'h10, 32'h14, 32'h18, 32'h1C, 0, 0, 0, 0);
        setv(2, 0, 32'h103, 3'b000, 1, 3'b000, 8'h01, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        setv(3, 1, 32'h3F0, 3'b101, 8, 3'b101, 8'h11, 32'h3F0, 32'h3F4, 32'h3F8, 32'h3FC,
             32'h400, 32'h404, 32'h408, 32'h40C);
        setv(4, 0, 32'h20,  3'b111, 1, 3'b000, 8'h01, 32'h20, 0, 0, 0, 0, 0, 0, 0);
        setv(6, 1, 32'h44,  3'b000, 1, 3'b000, 8'h01, 32'h44, 0, 0, 0, 0, 0, 0, 0);
`ifdef AHB_BURST_WRAP_EN
        setv(1, 0, 32'h1C,  3'b010, 4, 3'b010, 8'h01, 32'h1C, 32'h10, 32'h14, 32'h18, 0, 0, 0, 0);
        setv(5, 0, 32'h04,  3'b100, 8, 3'b100, 8'h01, 32'h04, 32'h08, 32'h0C, 32'h10,
             32'h14, 32'h18, 32'h1C, 32'h00);
        setv(7, 0, 32'h38,  3'b010, 4, 3'b010, 8'h01, 32'h38, 32'h3C, 32'h30, 32'h34, 0, 0, 0, 0);
        stall_exp = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h00};
`else
        setv(1, 0, 32'h1C,  3'b010, 4, 3'b011, 8'h01, 32'h1C, 32'h20, 32'h24, 32'h28, 0, 0, 0, 0);
        setv(5, 0, 32'h04,  3'b100, 8, 3'b101, 8'h01, 32'h04, 32'h08, 32'h0C, 32'h10,
             32'h14, 32'h18, 32'h1C, 32'h20);
        setv(7, 0, 32'h38,  3'b010, 4, 3'b011, 8'h01, 32'h38, 32'h3C, 32'h40, 32'h44, 0, 0, 0, 0);
        stall_exp = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};
`endif

        // Power-on reset
        @(negedge clk); @(negedge clk); #1;
        chk_zero("por");
        chk("hsize", hsize, 3'b010);
        chk("hprot", hprot, 7'b0000001);
        chk("hmastlock", hmastlock, 0);
        @(negedge clk); hreset_n = 1; #1;
        chk("por_rel_cmd_ready", cmd_ready, 0);
        @(negedge clk); #1;
        chk("por_edge_cmd_ready", cmd_ready, 1);
        chk("por_edge_htrans", htrans, 0);

        // Zero-wait burst table
        for (int i = 0; i < 8; i++) begin
            send(vt[i].wr, vt[i].addr, vt[i].burst, vt[i].wr, wdv(i, 0));
            chk($sformatf("v%0d_wrdy0", i), wdata_ready, vt[i].wr);
            for (int c = 1; c <= vt[i].n + 2; c++) begin
                @(negedge clk);
                cmd_valid   = 0;
                wdata_valid = vt[i].wr && (c < vt[i].n);
                wdata       = (c < vt[i].n) ? wdv(i, c) : 32'h0;
                hrdata      = (c >= 2 && c <= vt[i].n + 1) ? rdv(i, c - 2) : 32'hDEAD_BEEF;
                #1;
                if (c <= vt[i].n) begin
                    chk($sformatf("v%0d_htrans%0d", i, c), htrans, vt[i].ns[c-1] ? 2'b10 : 2'b11);
                    chk($sformatf("v%0d_haddr%0d", i, c), haddr, vt[i].ea[c-1]);
                    chk($sformatf("v%0d_hburst%0d", i, c), hburst, vt[i].hb);
                    chk($sformatf("v%0d_hwrite%0d", i, c), hwrite, vt[i].wr);
                end else begin
                    chk($sformatf("v%0d_htrans%0d", i, c), htrans, 2'b00);
                end
                if (vt[i].wr && c >= 2 && c <= vt[i].n + 1)
                    chk($sformatf("v%0d_hwdata%0d", i, c), hwdata, wdv(i, c - 2));
                chk($sformatf("v%0d_rvalid%0d", i, c), rdata_valid, !vt[i].wr && c >= 3);
                if (!vt[i].wr && c >= 3)
                    chk($sformatf("v%0d_rdata%0d", i, c), rdata, rdv(i, c - 3));
                if (c == vt[i].n + 1)
                    chk($sformatf("v%0d_drain_ready", i), cmd_ready, 1);
                chk($sformatf("v%0d_wrdy%0d", i, c), wdata_ready, vt[i].wr && c < vt[i].n);
            end
        end

        // Late write data on beat 2 -> two BUSY cycles
        send(1, 32'h40, 3'b011, 1, 32'hB0);
        step(1, 32'hB1); bus("busy_c1", 2'b10, 32'h40);
        step(0, 32'h0);  bus("busy_c2", 2'b11, 32'h44);
        chk("busy_c2_wrdy", wdata_ready, 0);
        chk("busy_c2_hwdata", hwdata, 32'hB0);
        step(0, 32'h0);  bus("busy_c3", 2'b01, 32'h48);
        chk("busy_c3_hwdata", hwdata, 32'hB1);
        step(1, 32'hB2); bus("busy_c4", 2'b01, 32'h48);
        chk("busy_c4_wrdy", wdata_ready, 1);
        chk("busy_c4_hwdata", hwdata, 32'hB1);
        step(1, 32'hB3); bus("busy_c5", 2'b11, 32'h48);
        step(0, 32'h0);  bus("busy_c6", 2'b11, 32'h4C);
        chk("busy_c6_hwdata", hwdata, 32'hB2);
        step(0, 32'h0);  chk("busy_c7_htrans", htrans, 0);
        chk("busy_c7_hwdata", hwdata, 32'hB3);
        chk("busy_c7_ready", cmd_ready, 1);
        step(0, 32'h0);

        // WRAP8 read at 0x04 with a 3-cycle stall on beat 1
        begin
            int  pulses;
            logic dp;
            pulses = 0; dp = 0;
            q_addr.delete(); q_rd.delete();
            send(0, 32'h04, 3'b100, 0, 32'h0);
            for (int c = 1; c < 40 && pulses < 8; c++) begin
                @(negedge clk);
                cmd_valid = 0;
                hready = !(c >= 2 && c <= 4);
                hrdata = 32'hC000_0000 + 32'(c);
                #1;
                if (c >= 2 && c <= 4) begin
                    bus($sformatf("stall_c%0d", c), 2'b11, 32'h08);
                    chk($sformatf("stall_c%0d_rvalid", c), rdata_valid, 0);
                end
                if (rdata_valid) begin
                    if (q_rd.size() == 0) chk("stall_rdata_extra", 1, 0);
                    else chk($sformatf("stall_rdata%0d", pulses), rdata, q_rd.pop_front());
                    pulses++;
                end
                if (dp && hready) q_rd.push_back(hrdata);
                if (htrans[1] && hready) q_addr.push_back(haddr);
                if (hready) dp = htrans[1];
            end
            chk("stall_pulses", pulses, 8);
            chk("stall_naddr", q_addr.size(), 8);
            for (int k = 0; k < 8 && k < q_addr.size(); k++)
                chk($sformatf("stall_addr%0d", k), q_addr[k], stall_exp[k]);
            hready = 1;
        end

        // Error response on beat 1 of an INCR8 write
        send(1, 32'h80, 3'b101, 1, 32'hE0);
        step(1, 32'hE1); bus("err_c1", 2'b10, 32'h80);
        step(1, 32'hE2); bus("err_c2", 2'b11, 32'h84);
        @(negedge clk); hresp = 1; hready = 0; wdata = 32'hE3; #1;
        bus("err_c3", 2'b11, 32'h88);
        chk("err_c3_wrdy", wdata_ready, 0);
        @(negedge clk); hresp = 1; hready = 1; #1;
        chk("err_c4_htrans", htrans, 0);
        chk("err_c4_err", err, 1);
        chk("err_c4_ready", cmd_ready, 0);
        @(negedge clk); hresp = 0; wdata_valid = 0;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h200; cmd_burst = 3'b000; #1;
        chk("err_c5_ready", cmd_ready, 1);
        chk("err_c5_err", err, 1);
        chk("err_c5_htrans", htrans, 0);
        step(0, 32'h0);
        chk("err_c6_err", err, 0);
        bus("err_c6", 2'b10, 32'h200);
        step(0, 32'h0); step(0, 32'h0); step(0, 32'h0);

        // Reset during beat 2 of an INCR8 write
        send(1, 32'h300, 3'b101, 1, 32'h50);
        step(1, 32'h51); step(1, 32'h52);
        @(negedge clk); wdata_valid = 1; wdata = 32'h53; #1;
        bus("rst_beat2", 2'b11, 32'h308);
        chk("rst_beat2_hwrite", hwrite, 1);
        hreset_n = 0; #1;
        chk_zero("midrst");
        @(negedge clk); hreset_n = 1; wdata_valid = 0; #1;
        chk("midrst_rel_ready", cmd_ready, 0);
        @(negedge clk); #1;
        chk("midrst_edge_ready", cmd_ready, 1);
        chk("midrst_edge_htrans", htrans, 0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
